// File: rtl/input_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_ctrl
// Description : Conditions a bank of asynchronous limit-switch/index inputs.
//               Each channel has a two-flop synchroniser and a per-channel
//               debounce FSM. All channels are advanced by one shared
//               sample-tick prescaler. The outputs are filtered levels plus
//               sticky rise/fall event flags, which the bus layer clears.
// Optional    : `define INPUT_DEBOUNCE_IRQ_EN adds the irq_mask input and a
//               registered irq output.
// Ports       : clk         - system clock
//               reset       - asynchronous active-high reset
//               async_in    - raw asynchronous inputs [NCH]
//               enable      - 1 = prescaler and debounce FSMs run
//               evt_clr     - per-channel level clear for rise/fall flags
//               irq_mask    - per-channel interrupt mask (optional)
//               irq         - OR of masked event flags, registered (optional)
//               filt_out    - debounced level [NCH]
//               rise_evt    - sticky accepted 0->1 flag [NCH]
//               fall_evt    - sticky accepted 1->0 flag [NCH]
//               sample_tick - one-cycle pulse at each sample instant
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce_ctrl #(
    parameter int NCH      = 8,
    parameter int PRESCALE = 1000,
    parameter int DB_COUNT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] async_in,
    input  logic           enable,
    input  logic [NCH-1:0] evt_clr,
`ifdef INPUT_DEBOUNCE_IRQ_EN
    input  logic [NCH-1:0] irq_mask,
    output logic           irq,
`endif
    output logic [NCH-1:0] filt_out,
    output logic [NCH-1:0] rise_evt,
    output logic [NCH-1:0] fall_evt,
    output logic           sample_tick
);

    localparam int              c_PW       = $clog2(PRESCALE);
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);
    localparam logic [c_PW-1:0] c_PRE_ONE  = c_PW'(1);
    localparam logic [3:0]      c_DB       = 4'(DB_COUNT);

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_PEND_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_PEND_LO   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser: free-running, independent of enable
    // ------------------------------------------------------------------
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_pre;
    logic            w_tick;

    assign w_tick      = enable && (r_pre == c_PRE_LAST);
    assign sample_tick = w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (!enable || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce FSMs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        state_t     r_state;
        state_t     w_state_nxt;
        logic [3:0] r_cnt;
        logic [3:0] w_cnt_nxt;
        logic [3:0] w_cnt_inc;
        logic       w_s;
        logic       w_set_rise;
        logic       w_set_fall;
        logic       r_filt;
        logic       r_rise;
        logic       r_fall;

        assign w_s       = r_sync2[gi];
        assign w_cnt_inc = r_cnt + 4'd1;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_set_rise  = 1'b0;
            w_set_fall  = 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_STABLE_LO: begin
                        if (w_s) begin
                            // With a debounce count of one the first differing
                            // sample is already enough to accept the new level.
                            if (c_DB == 4'd1) begin
                                w_state_nxt = ST_STABLE_HI;
                                w_set_rise  = 1'b1;
                                w_cnt_nxt   = 4'd0;
                            end else begin
                                w_state_nxt = ST_PEND_HI;
                                w_cnt_nxt   = 4'd1;
                            end
                        end
                    end
                    ST_PEND_HI: begin
                        if (w_s) begin
                            if (w_cnt_inc == c_DB) begin
                                w_state_nxt = ST_STABLE_HI;
                                w_set_rise  = 1'b1;
                                w_cnt_nxt   = 4'd0;
                            end else begin
                                w_cnt_nxt   = w_cnt_inc;
                            end
                        end else begin
                            w_state_nxt = ST_STABLE_LO;
                            w_cnt_nxt   = 4'd0;
                        end
                    end
                    ST_STABLE_HI: begin
                        if (!w_s) begin
                            if (c_DB == 4'd1) begin
                                w_state_nxt = ST_STABLE_LO;
                                w_set_fall  = 1'b1;
                                w_cnt_nxt   = 4'd0;
                            end else begin
                                w_state_nxt = ST_PEND_LO;
                                w_cnt_nxt   = 4'd1;
                            end
                        end
                    end
                    ST_PEND_LO: begin
                        if (!w_s) begin
                            if (w_cnt_inc == c_DB) begin
                                w_state_nxt = ST_STABLE_LO;
                                w_set_fall  = 1'b1;
                                w_cnt_nxt   = 4'd0;
                            end else begin
                                w_cnt_nxt   = w_cnt_inc;
                            end
                        end else begin
                            w_state_nxt = ST_STABLE_HI;
                            w_cnt_nxt   = 4'd0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_STABLE_LO;
                        w_cnt_nxt   = 4'd0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_STABLE_LO;
                r_cnt   <= 4'd0;
                r_filt  <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_set_rise) begin
                    r_filt <= 1'b1;
                end else if (w_set_fall) begin
                    r_filt <= 1'b0;
                end
                // A new event takes priority over a simultaneous clear.
                r_rise <= w_set_rise | (r_rise & ~evt_clr[gi]);
                r_fall <= w_set_fall | (r_fall & ~evt_clr[gi]);
            end
        end

        assign filt_out[gi] = r_filt;
        assign rise_evt[gi] = r_rise;
        assign fall_evt[gi] = r_fall;
    end

`ifdef INPUT_DEBOUNCE_IRQ_EN
    // ------------------------------------------------------------------
    // Interrupt: registered from the flag registers, so it lags a flag
    // set or clear by one cycle.
    // ------------------------------------------------------------------
    logic r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |((rise_evt | fall_evt) & irq_mask);
        end
    end

    assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debounce_ctrl
// Description : Randomised self-checking bench for input_debounce_ctrl.
//               Each cycle the stimulus process pushes the expected outputs
//               from a behavioural reference model into a queue. A monitor
//               pops the queue on the falling edge and compares the entry
//               with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce_ctrl;

    localparam int NCH  = 8;
    localparam int P    = 4;
    localparam int DB   = 3;
    localparam int NCYC = 4000;

    logic           clk      = 1'b0;
    logic           reset    = 1'b1;
    logic           enable   = 1'b0;
    logic [NCH-1:0] async_in = '0;
    logic [NCH-1:0] evt_clr  = '0;
    logic [NCH-1:0] filt_out;
    logic [NCH-1:0] rise_evt;
    logic [NCH-1:0] fall_evt;
    logic           sample_tick;
`ifdef INPUT_DEBOUNCE_IRQ_EN
    logic [NCH-1:0] irq_mask = '0;
    logic           irq;
`endif

    always #5 clk = ~clk;

    input_debounce_ctrl #(
        .NCH      (NCH),
        .PRESCALE (P),
        .DB_COUNT (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .async_in    (async_in),
        .enable      (enable),
        .evt_clr     (evt_clr),
`ifdef INPUT_DEBOUNCE_IRQ_EN
        .irq_mask    (irq_mask),
        .irq         (irq),
`endif
        .filt_out    (filt_out),
        .rise_evt    (rise_evt),
        .fall_evt    (fall_evt),
        .sample_tick (sample_tick)
    );

    typedef struct packed {
        logic [NCH-1:0] f;
        logic [NCH-1:0] r;
        logic [NCH-1:0] fl;
        logic           t;
        logic           q;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: accepted level per channel plus a count of
    // consecutive sample ticks that disagree with it.
    // ------------------------------------------------------------------
    logic [NCH-1:0] m_lvl, m_rise, m_fall, m_s1, m_s2;
    int             m_run [NCH];
    int             m_pc;
    logic           m_irq;

    task automatic model_reset();
        m_lvl  = '0;
        m_rise = '0;
        m_fall = '0;
        m_s1   = '0;
        m_s2   = '0;
        m_pc   = 0;
        m_irq  = 1'b0;
        for (int i = 0; i < NCH; i++) m_run[i] = 0;
    endtask

    // Applies what happens at the next rising edge, using the inputs driven now.
    task automatic model_step();
        logic           tick;
        logic [NCH-1:0] set_r, set_f;
        tick  = enable && (m_pc == P - 1);
        set_r = '0;
        set_f = '0;
        for (int i = 0; i < NCH; i++) begin
            if (tick) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = m_s2[i];
                        if (m_s2[i]) set_r[i] = 1'b1;
                        else         set_f[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
`ifdef INPUT_DEBOUNCE_IRQ_EN
        m_irq = |((m_rise | m_fall) & irq_mask);
`endif
        m_rise = set_r | (m_rise & ~evt_clr);
        m_fall = set_f | (m_fall & ~evt_clr);
        m_pc   = enable ? (m_pc + 1) % P : 0;
        m_s2   = m_s1;
        m_s1   = async_in;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t e_mon;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                chk("filt_out",    32'(filt_out),    32'(e_mon.f));
                chk("rise_evt",    32'(rise_evt),    32'(e_mon.r));
                chk("fall_evt",    32'(fall_evt),    32'(e_mon.fl));
                chk("sample_tick", 32'(sample_tick), 32'(e_mon.t));
`ifdef INPUT_DEBOUNCE_IRQ_EN
                chk("irq",         32'(irq),         32'(e_mon.q));
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int   hold [NCH];
    int   en_hold  = 0;
    int   rst_hold = 3;
    logic prev_rst;
    exp_t e_push;

    initial begin
        model_reset();
        for (int i = 0; i < NCH; i++) hold[i] = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            prev_rst = reset;
            // Reset is driven between clock edges, so it acts asynchronously.
            if (rst_hold > 0) begin
                reset = 1'b1;
                rst_hold--;
            end else begin
                reset = 1'b0;
                if (cyc > 40 && ($urandom % 300) == 0) rst_hold = $urandom_range(1, 3);
            end

            if (cyc < 24) begin
                // Quiet start: reset release with all inputs low.
                enable   = 1'b1;
                async_in = '0;
                evt_clr  = '0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (hold[i] == 0) begin
                        async_in[i] = 1'($urandom % 2);
                        hold[i]     = $urandom_range(1, 18);
                    end else begin
                        hold[i]--;
                    end
                    evt_clr[i] = (($urandom % 10) == 0);
                end
                if (en_hold == 0) begin
                    enable  = (($urandom % 6) != 0);
                    en_hold = $urandom_range(1, 30);
                end else begin
                    en_hold--;
                end
`ifdef INPUT_DEBOUNCE_IRQ_EN
                if (($urandom % 50) == 0) irq_mask = NCH'($urandom);
`endif
            end

            if (reset) model_reset();
            e_push.f  = m_lvl;
            e_push.r  = m_rise;
            e_push.fl = m_fall;
            e_push.t  = enable && !reset && (m_pc == P - 1);
            e_push.q  = m_irq;
            exp_q.push_back(e_push);

            if (reset && !prev_rst) begin
                #1;
                chk("rst_filt_out", 32'(filt_out), 32'd0);
                chk("rst_rise_evt", 32'(rise_evt), 32'd0);
                chk("rst_fall_evt", 32'(fall_evt), 32'd0);
            end

            if (!reset) model_step();
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
